// File: rtl/key_step_ctrl.sv
// Debounced push-button stepper for an up/down counter with hold-to-auto-repeat.
// step/cnt update DEB_CYCLES+2 edges after the first edge that samples button=1.
module key_step_ctrl #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = 8'h1F,
  parameter int DEB_CYCLES = 1000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REP_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [6:0]       ctrl,
  output logic [WIDTH-1:0] cnt,
  output logic             step,
  output logic             limit,
  output logic [2:0]       state
);

  localparam int MAXC = (DEB_CYCLES > HOLD_CYCLES)
                      ? ((DEB_CYCLES > REP_CYCLES) ? DEB_CYCLES : REP_CYCLES)
                      : ((HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES);
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] DEB_END  = TW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_END = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_END  = TW'(REP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } state_t;

  state_t          st;
  logic            btn_m;
  logic            btn_s;
  logic [TW-1:0]   timer;
  logic            at_lim;
  logic [WIDTH-1:0] cnt_nxt;
  logic            unused_ctrl;

  assign state       = st;
  assign unused_ctrl = ^ctrl[6:3];

  // Saturate blocks only the move that would cross the range end in the chosen direction.
  always_comb begin
    at_lim  = ctrl[1] & (ctrl[0] ? (cnt == '1) : (cnt == '0));
    cnt_nxt = ctrl[0] ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      st    <= IDLE;
      timer <= '0;
      cnt   <= RST_VAL;
      step  <= 1'b0;
      limit <= 1'b0;
    end else begin
      btn_m <= button;
      btn_s <= btn_m;
      step  <= 1'b0;
      limit <= 1'b0;
      case (st)
        IDLE: begin
          if (btn_s) begin
            st    <= PRESS_DB;
            timer <= '0;
          end
        end
        PRESS_DB: begin
          if (!btn_s) begin
            st <= IDLE;
          end else if (timer == DEB_END) begin
            st    <= HELD;
            timer <= '0;
            step  <= 1'b1;
            limit <= at_lim;
            if (!at_lim) cnt <= cnt_nxt;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            st    <= RELEASE_DB;
            timer <= '0;
          end else if (ctrl[2] && timer == HOLD_END) begin
            st    <= REPEAT;
            timer <= '0;
            step  <= 1'b1;
            limit <= at_lim;
            if (!at_lim) cnt <= cnt_nxt;
          end else if (timer != HOLD_END) begin
            // Parks at HOLD_END so enabling repeat later starts it immediately.
            timer <= timer + TW'(1);
          end
        end
        REPEAT: begin
          if (!btn_s) begin
            st    <= RELEASE_DB;
            timer <= '0;
          end else if (!ctrl[2]) begin
            st    <= HELD;
            timer <= '0;
          end else if (timer == REP_END) begin
            timer <= '0;
            step  <= 1'b1;
            limit <= at_lim;
            if (!at_lim) cnt <= cnt_nxt;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RELEASE_DB: begin
          if (btn_s) begin
            st    <= HELD;
            timer <= '0;
          end else if (timer == DEB_END) begin
            st    <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          st    <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_step_ctrl.sv
// Randomized and directed bench for key_step_ctrl against a run-length behavioural model.
module tb_key_step_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [6:0] ctrl;
  logic [7:0] cnt;
  logic       step;
  logic       limit;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  key_step_ctrl #(
    .WIDTH(8), .RST_VAL(8'h1F),
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REP_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .ctrl(ctrl),
    .cnt(cnt), .step(step), .limit(limit), .state(state)
  );

  always #5 clk = ~clk;

  // Model: debounced level plus run lengths of the 2-cycle-delayed button.
  bit       m_init = 0;
  bit [1:0] pipe;
  bit       pressed;
  bit       rep;
  int       hi_run, lo_run, age;
  bit [7:0] m_cnt;
  bit       m_step, m_lim;
  int       m_steps;

  function automatic int model_state();
    if (!pressed) return (hi_run > 0) ? 1 : 0;
    if (lo_run > 0) return 4;
    return rep ? 3 : 2;
  endfunction

  always @(posedge clk) begin
    bit bs, fire;
    if (rst) begin
      pipe = 2'b00; pressed = 0; rep = 0; hi_run = 0; lo_run = 0; age = 0;
      m_cnt = 8'h1F; m_step = 0; m_lim = 0; m_init = 1;
    end else begin
      bs = pipe[1];
      pipe = {pipe[0], button};
      fire = 0;
      if (!pressed) begin
        hi_run = bs ? hi_run + 1 : 0;
        if (hi_run == DEB + 1) begin
          pressed = 1; hi_run = 0; lo_run = 0; rep = 0; age = 0; fire = 1;
        end
      end else if (!bs) begin
        lo_run++; rep = 0;
        if (lo_run == DEB + 1) begin pressed = 0; lo_run = 0; end
      end else if (lo_run > 0) begin
        lo_run = 0; age = 0; rep = 0;
      end else if (!rep) begin
        if (ctrl[2] && age == HOLD - 1) begin rep = 1; age = 0; fire = 1; end
        else if (age < HOLD - 1) age++;
      end else begin
        if (!ctrl[2]) begin rep = 0; age = 0; end
        else if (age == REP - 1) begin age = 0; fire = 1; end
        else age++;
      end
      m_step = fire;
      m_lim  = 0;
      if (fire) begin
        m_steps++;
        if (ctrl[1] && ((ctrl[0] && m_cnt == 8'hFF) || (!ctrl[0] && m_cnt == 8'h00))) m_lim = 1;
        else m_cnt = ctrl[0] ? m_cnt + 8'd1 : m_cnt - 8'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int dut_steps, dut_lims, lim_wo_step;

  always @(negedge clk) begin
    if (m_init) begin
      chk("cnt", {24'd0, cnt}, {24'd0, m_cnt});
      chk("step", {31'd0, step}, {31'd0, m_step});
      chk("limit", {31'd0, limit}, {31'd0, m_lim});
      chk("state", {29'd0, state}, model_state());
      if (step === 1'b1) dut_steps++;
      if (limit === 1'b1) dut_lims++;
      if (limit === 1'b1 && step !== 1'b1) lim_wo_step++;
    end
  end

  task automatic cyc(input logic b, input logic [6:0] c, input logic r);
    button = b; ctrl = c; rst = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo, input logic [6:0] c);
    repeat (hi) cyc(1'b1, c, 1'b0);
    repeat (lo) cyc(1'b0, c, 1'b0);
  endtask

  task automatic clr();
    dut_steps = 0; dut_lims = 0; lim_wo_step = 0; m_steps = 0;
  endtask

  task automatic do_reset();
    cyc(1'b0, 7'd0, 1'b1);
    cyc(1'b0, 7'd0, 1'b1);
    clr();
  endtask

  initial begin
    button = 0; ctrl = 0; rst = 1;
    do_reset();
    chk("rst_cnt", {24'd0, cnt}, 32'h1F);
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_step", {31'd0, step}, 0);
    chk("rst_limit", {31'd0, limit}, 0);

    // Clean single press
    press(8, 12, 7'b0000001);
    chk("clean_steps", dut_steps, 1);
    chk("clean_cnt", {24'd0, cnt}, 32'h20);
    chk("clean_model_cnt", {24'd0, m_cnt}, 32'h20);
    chk("clean_state", {29'd0, state}, 0);

    // Bounce rejection
    do_reset();
    repeat (2) begin press(2, 2, 7'b0000001); end
    press(0, 10, 7'b0000001);
    chk("bounce_steps", dut_steps, 0);
    chk("bounce_cnt", {24'd0, cnt}, 32'h1F);

    // Auto-repeat: steps at samples 5, 15, 18, 21, 24, 27, 30
    do_reset();
    press(30, 12, 7'b0000101);
    chk("auto_steps", dut_steps, 7);
    chk("auto_model_steps", m_steps, 7);
    chk("auto_cnt", {24'd0, cnt}, 32'h26);

    // Down/wrap: 32 presses from 0x1F
    do_reset();
    repeat (32) press(8, 8, 7'b0000000);
    chk("down_steps", dut_steps, 32);
    chk("down_cnt", {24'd0, cnt}, 32'hFF);
    chk("down_model_cnt", {24'd0, m_cnt}, 32'hFF);

    clr();
    press(8, 8, 7'b0000001);
    chk("wrap_up_cnt", {24'd0, cnt}, 32'h00);
    chk("wrap_up_lims", dut_lims, 0);

    clr();
    press(8, 8, 7'b0000010);
    chk("sat_down_cnt", {24'd0, cnt}, 32'h00);
    chk("sat_down_steps", dut_steps, 1);
    chk("sat_down_lims", dut_lims, 1);

    press(8, 8, 7'b0000000);
    clr();
    press(8, 8, 7'b0000011);
    chk("sat_up_cnt", {24'd0, cnt}, 32'hFF);
    chk("sat_up_steps", dut_steps, 1);
    chk("sat_up_lims", dut_lims, 1);
    chk("sat_up_lim_alone", lim_wo_step, 0);

    // Reset while auto-repeating
    do_reset();
    repeat (20) cyc(1'b1, 7'b0000101, 1'b0);
    chk("pre_rst_steps", dut_steps, 3);
    cyc(1'b1, 7'b0000101, 1'b1);
    chk("midrst_cnt", {24'd0, cnt}, 32'h1F);
    chk("midrst_state", {29'd0, state}, 0);
    chk("midrst_step", {31'd0, step}, 0);
    clr();
    repeat (16) cyc(1'b1, 7'b0000101, 1'b0);
    chk("postrst_steps", dut_steps, 1);
    chk("postrst_cnt", {24'd0, cnt}, 32'h20);
    repeat (2) cyc(1'b1, 7'b0000101, 1'b0);
    chk("postrst_repeat_steps", dut_steps, 2);
    press(0, 12, 7'b0000101);

    // Randomized runs of button level with random switches and rare resets
    clr();
    for (int seg = 0; seg < 250; seg++) begin
      logic       b;
      logic [6:0] c;
      int         len;
      b   = 1'($urandom_range(0, 1));
      c   = 7'($urandom);
      len = (b && $urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 15) == 0) c = 7'($urandom);
        cyc(b, c, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end
    end
    chk("rand_lim_alone", lim_wo_step, 0);
    chk("rand_step_total", dut_steps, m_steps);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
